sparse_output_packer: RTL



---
 rtl/sparse_output_packer.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/sparse_output_packer.sv
// -----------------------------------------------------------------------------
// sparse_output_packer
//
// Drain engine for the accumulator buffer. After a channel group completes it
// scans every bank/entry of the output tile, applies ReLU plus
// bitwidth-dependent saturation, zero-skip encodes the result and writes
// (value, zero-run index) pairs sequentially into the OARAM.
//
// Ports:
//   clk                 clock
//   reset_n             synchronous active-low reset
//   start               channel-group-done pulse, sampled only in idle
//   bitwidth            0: 8-bit, 1: 4-bit, 2: 2-bit, 3: 8-bit (latched on start)
//   buffer_bank_read    bank read address (0 outside the scan)
//   buffer_bank_entry   entry read address (0 outside the scan)
//   buffer_data_read    signed buffer data, valid one cycle after the address
//   oaram_value         encoded value
//   oaram_indices_value number of zeros preceding this value
//   oaram_address       OARAM write address
//   oaram_write_enable  OARAM write strobe
//   busy                high from the cycle after start is accepted until done
//   done                one-cycle completion pulse
//   word_count          words written, saturates at 2^RAM_WIDTH
//   overflow            sticky, set when a write had to be dropped
// -----------------------------------------------------------------------------
module sparse_output_packer #(
    parameter int unsigned RAM_WIDTH   = 10,
    parameter int unsigned BANK_COUNT  = 32,
    parameter int unsigned TILE_SIZE   = 128,
    parameter int unsigned INDEX_WIDTH = 4,
    parameter int unsigned VALUE_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [1:0]                    bitwidth,
    output logic [$clog2(BANK_COUNT)-1:0] buffer_bank_read,
    output logic [$clog2(TILE_SIZE)-1:0]  buffer_bank_entry,
    input  logic [VALUE_WIDTH-1:0]        buffer_data_read,
    output logic [VALUE_WIDTH-1:0]        oaram_value,
    output logic [INDEX_WIDTH-1:0]        oaram_indices_value,
    output logic [RAM_WIDTH-1:0]          oaram_address,
    output logic                          oaram_write_enable,
    output logic                          busy,
    output logic                          done,
    output logic [RAM_WIDTH:0]            word_count,
    output logic                          overflow
);

    localparam int unsigned BankW  = $clog2(BANK_COUNT);
    localparam int unsigned EntryW = $clog2(TILE_SIZE);

    localparam logic [BankW-1:0]       LastBank  = BankW'(BANK_COUNT - 1);
    localparam logic [EntryW-1:0]      LastEntry = EntryW'(TILE_SIZE - 1);
    localparam logic [INDEX_WIDTH-1:0] MaxRun    = '1;
    localparam logic [RAM_WIDTH:0]     Capacity  = (RAM_WIDTH + 1)'(1) << RAM_WIDTH;

    localparam logic signed [VALUE_WIDTH-1:0] Sat4 = VALUE_WIDTH'(15);
    localparam logic signed [VALUE_WIDTH-1:0] Sat2 = VALUE_WIDTH'(3);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDrain,
        StDone
    } state_e;

    state_e                   state_q;
    logic [BankW-1:0]         bank_q;
    logic [EntryW-1:0]        entry_q;
    logic [1:0]               mode_q;
    logic                     data_valid_q;
    logic                     drain_cnt_q;
    logic [INDEX_WIDTH-1:0]   run_q;
    logic [VALUE_WIDTH-1:0]   value_q;
    logic [INDEX_WIDTH-1:0]   index_q;
    logic [RAM_WIDTH-1:0]     addr_q;
    logic                     we_q;
    logic                     busy_q;
    logic                     done_q;
    logic [RAM_WIDTH:0]       count_q;
    logic                     overflow_q;

    logic signed [VALUE_WIDTH-1:0] data_s;
    logic [VALUE_WIDTH-1:0]        sat_value;
    logic                          emit;
    logic [INDEX_WIDTH-1:0]        emit_index;
    logic [INDEX_WIDTH-1:0]        run_d;

    // ReLU followed by saturation to the latched output precision.
    always_comb begin
        data_s    = signed'(buffer_data_read);
        sat_value = buffer_data_read;
        if (data_s < 0) begin
            sat_value = '0;
        end else begin
            case (mode_q)
                2'd1:    if (data_s > Sat4) sat_value = Sat4;
                2'd2:    if (data_s > Sat2) sat_value = Sat2;
                default: ;
            endcase
        end
    end

    // Zero-skip encoding. A run that reaches MaxRun is flushed as a (0, MaxRun)
    // marker word; a residual run at the end of the tile is simply dropped.
    always_comb begin
        emit       = 1'b0;
        emit_index = run_q;
        run_d      = run_q;
        if (data_valid_q) begin
            if (sat_value != '0) begin
                emit  = 1'b1;
                run_d = '0;
            end else if (run_q == MaxRun) begin
                emit  = 1'b1;
                run_d = '0;
            end else begin
                run_d = run_q + INDEX_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            bank_q       <= '0;
            entry_q      <= '0;
            mode_q       <= '0;
            data_valid_q <= 1'b0;
            drain_cnt_q  <= 1'b0;
            run_q        <= '0;
            value_q      <= '0;
            index_q      <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
        end else begin
            we_q         <= 1'b0;
            done_q       <= 1'b0;
            data_valid_q <= (state_q == StScan);
            run_q        <= run_d;

            if (emit) begin
                if (count_q < Capacity) begin
                    we_q    <= 1'b1;
                    value_q <= sat_value;
                    index_q <= emit_index;
                    addr_q  <= count_q[RAM_WIDTH-1:0];
                    count_q <= count_q + (RAM_WIDTH + 1)'(1);
                end else begin
                    overflow_q <= 1'b1;
                end
            end

            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q    <= StScan;
                        busy_q     <= 1'b1;
                        mode_q     <= bitwidth;
                        count_q    <= '0;
                        overflow_q <= 1'b0;
                        run_q      <= '0;
                        addr_q     <= '0;
                        bank_q     <= '0;
                        entry_q    <= '0;
                    end
                end
                StScan: begin
                    // Bank is the inner loop, entry the outer one.
                    if (bank_q == LastBank) begin
                        bank_q <= '0;
                        if (entry_q == LastEntry) begin
                            entry_q     <= '0;
                            state_q     <= StDrain;
                            drain_cnt_q <= 1'b0;
                        end else begin
                            entry_q <= entry_q + EntryW'(1);
                        end
                    end else begin
                        bank_q <= bank_q + BankW'(1);
                    end
                end
                StDrain: begin
                    // Two cycles let the last data word and its write retire.
                    drain_cnt_q <= 1'b1;
                    if (drain_cnt_q) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign buffer_bank_read    = bank_q;
    assign buffer_bank_entry   = entry_q;
    assign oaram_value         = value_q;
    assign oaram_indices_value = index_q;
    assign oaram_address       = addr_q;
    assign oaram_write_enable  = we_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign word_count          = count_q;
    assign overflow            = overflow_q;

endmodule
